sifive_reset_sequencer: RTL

Single-clock reset sequencer for the board shell. It waits for a filtered, already-synchronised PLL lock indication, holds every downstream domain in reset for a fixed debounce interval, then releases the domain reset requests one at a time in ascending order with a fixed gap between them. Loss of lock or a software reset request re-enters the sequence. Each `domain_reset[k]` is a level request that the consuming clock domain passes through its own reset synchroniser.

---
 rtl/sifive_reset_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sifive_reset_sequencer.sv
// sifive_reset_sequencer: single-clock board-shell reset sequencer.
// Waits for a filtered PLL lock, holds all domains for 2^HOLD_BITS cycles,
// then releases domain resets in ascending order, STEP_CYCLES apart.
// Optional feature macro: SIFIVE_RESET_SEQ_LOSS_COUNT_EN adds an 8-bit
// saturating lock-loss abort counter output (lock_loss_count).
module sifive_reset_sequencer #(
  parameter int DOMAINS     = 4,
  parameter int HOLD_BITS   = 8,
  parameter int STEP_CYCLES = 16,
  parameter int LOCK_FILTER = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               locked,
  input  logic               sw_reset_req,
  output logic [DOMAINS-1:0] domain_reset,
  output logic               ready,
  output logic               sw_reset_ack,
  output logic [1:0]         state
`ifdef SIFIVE_RESET_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0]         lock_loss_count
`endif
);

  localparam int LW = $clog2(LOCK_FILTER + 1);
  localparam int HW = HOLD_BITS + 1;
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int IW = $clog2(DOMAINS) + 1;

  // Terminal counts are "last value before the event" so each compare
  // matches on the edge that completes the interval.
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((1 << HOLD_BITS) - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DOMAINS - 1);
  localparam logic [DOMAINS-1:0] ONE  = DOMAINS'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t         state_q;
  logic [LW-1:0]  lock_cnt;
  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  step_cnt;
  logic [IW-1:0]  idx;
  logic           pending;

  assign state = state_q;

  // Sequencer FSM; every output is a register written here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      domain_reset <= '1;
      ready        <= 1'b0;
      sw_reset_ack <= 1'b0;
      lock_cnt     <= '0;
      hold_cnt     <= '0;
      step_cnt     <= '0;
      idx          <= '0;
      pending      <= 1'b0;
`ifdef SIFIVE_RESET_SEQ_LOSS_COUNT_EN
      lock_loss_count <= '0;
`endif
    end else begin
      sw_reset_ack <= 1'b0;
      if (state_q == WAIT_LOCK) begin
        // Software requests are ignored until lock is qualified.
        if (!locked) begin
          lock_cnt <= '0;
        end else if (lock_cnt == LOCK_LAST) begin
          lock_cnt <= '0;
          hold_cnt <= '0;
          state_q  <= HOLD;
        end else begin
          lock_cnt <= lock_cnt + 1'b1;
        end
      end else if (!locked) begin
        // Lock loss beats a simultaneous software request, but the request
        // is still remembered so its ack fires after the next full sequence.
        domain_reset <= '1;
        ready        <= 1'b0;
        lock_cnt     <= '0;
        state_q      <= WAIT_LOCK;
        if (sw_reset_req) pending <= 1'b1;
`ifdef SIFIVE_RESET_SEQ_LOSS_COUNT_EN
        if (lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 1'b1;
`endif
      end else if (sw_reset_req) begin
        domain_reset <= '1;
        ready        <= 1'b0;
        hold_cnt     <= '0;
        pending      <= 1'b1;
        state_q      <= HOLD;
      end else begin
        case (state_q)
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              domain_reset[0] <= 1'b0;
              if (DOMAINS == 1) begin
                state_q <= RUN;
                ready   <= 1'b1;
                if (pending) begin
                  sw_reset_ack <= 1'b1;
                  pending      <= 1'b0;
                end
              end else begin
                state_q  <= RELEASE;
                idx      <= IW'(1);
                step_cnt <= '0;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (step_cnt == STEP_LAST) begin
              domain_reset <= domain_reset & ~(ONE << idx);
              step_cnt     <= '0;
              idx          <= idx + 1'b1;
              if (idx == LAST_IDX) begin
                state_q <= RUN;
                ready   <= 1'b1;
                if (pending) begin
                  sw_reset_ack <= 1'b1;
                  pending      <= 1'b0;
                end
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
